// File: rtl/tdc_cali_pkg.sv
// Shared types and helpers for the TDC auto-calibration block: FSM states,
// default widths and the saturating bin increment.
package tdc_cali_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETTLE,
    ACQUIRE,
    DONE
  } cali_state_e;

  localparam int unsigned CODE_W_DEF = 7;
  localparam int unsigned CNT_W_DEF  = 16;

  // Callers zero-extend into 32 bits and truncate the result back to CNT_W.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/tdc_hist_ram.sv
// Histogram storage: simple dual-port RAM, one write port, registered read (1 cycle).
// Read-during-write to the same address returns the old word; the caller forwards around it.
module tdc_hist_ram #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1 << AW) - 1];
  logic [DW-1:0] rd_dat_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rd_dat_q <= mem[raddr];
    end
  end

  assign rdata = rd_dat_q;

endmodule

// File: rtl/tdc_cali_ctrl.sv
// Calibration sequencer: CLEAR -> SETTLE -> ACQUIRE N_HITS code-density hits -> DONE; o_done 2 cycles after last hit,
// reads 1 cycle and IDLE-only, hits accepted every cycle. Define TDC_CALI_TIMEOUT_EN for the ACQUIRE timeout.
module tdc_cali_ctrl
  import tdc_cali_pkg::*;
#(
  parameter int unsigned CODE_W      = CODE_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned N_HITS      = 32768,
  parameter int unsigned SETTLE_CYC  = 4096,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_hit_valid,
  input  logic [CODE_W-1:0] i_hit_code,
  input  logic              i_rd_en,
  input  logic [CODE_W-1:0] i_rd_addr,
  output logic              o_cali_control,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_valid,
  output logic [CNT_W-1:0]  o_rd_data,
  output logic              o_timeout
);

  localparam int unsigned      NBINS   = 1 << CODE_W;
  localparam int unsigned      SC_W    = $clog2(SETTLE_CYC + 1);
  localparam int unsigned      HC_W    = $clog2(N_HITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (N_HITS == 0 || SETTLE_CYC == 0 || TIMEOUT_CYC == 0) begin : g_bad_param
    $error("tdc_cali_ctrl: N_HITS, SETTLE_CYC and TIMEOUT_CYC must be non-zero");
  end

  cali_state_e       state_q, state_d;
  logic [CODE_W-1:0] clr_addr_q, clr_addr_d;
  logic [SC_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [HC_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic              s1_vld_q, s1_vld_d;
  logic [CODE_W-1:0] s1_code_q, s1_code_d;
  logic              wr_vld_q, wr_vld_d;
  logic [CODE_W-1:0] wr_code_q, wr_code_d;
  logic [CNT_W-1:0]  wr_dat_q, wr_dat_d;
  logic              cali_q, cali_d;
  logic              done_q, done_d;
  logic              rd_vld_q, rd_vld_d;

  logic              hit_acc, last_hit, tmo_hit;
  logic [CNT_W-1:0]  rmw_base;
  logic              ram_we, ram_re;
  logic [CODE_W-1:0] ram_waddr, ram_raddr;
  logic [CNT_W-1:0]  ram_wdata, ram_rdata;

`ifdef TDC_CALI_TIMEOUT_EN
  localparam int unsigned TC_W = $clog2(TIMEOUT_CYC + 1);
  logic [TC_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            tmo_q, tmo_d;
`endif

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    settle_cnt_d = settle_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    tmo_hit      = 1'b0;
`ifdef TDC_CALI_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    tmo_d        = tmo_q;
`endif
    hit_acc  = (state_q == ACQUIRE) && i_hit_valid;
    last_hit = hit_acc && (hit_cnt_q == HC_W'(N_HITS - 1));

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
`ifdef TDC_CALI_TIMEOUT_EN
          tmo_d      = 1'b0;
`endif
        end
      end
      CLEAR: begin
        clr_addr_d = clr_addr_q + CODE_W'(1);
        if (clr_addr_q == CODE_W'(NBINS - 1)) begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
        end
      end
      SETTLE: begin
        settle_cnt_d = settle_cnt_q + SC_W'(1);
        if (settle_cnt_q == SC_W'(SETTLE_CYC - 1)) begin
          state_d   = ACQUIRE;
          hit_cnt_d = '0;
`ifdef TDC_CALI_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      ACQUIRE: begin
        if (hit_acc) begin
          hit_cnt_d = hit_cnt_q + HC_W'(1);
        end
`ifdef TDC_CALI_TIMEOUT_EN
        // A final hit landing on the timeout cycle still counts as a normal finish.
        tmo_cnt_d = tmo_cnt_q + TC_W'(1);
        tmo_hit   = !last_hit && (tmo_cnt_q == TC_W'(TIMEOUT_CYC - 1));
        if (tmo_hit) begin
          tmo_d = 1'b1;
        end
`endif
        if (last_hit || tmo_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cali_d   = (state_d == SETTLE) || (state_d == ACQUIRE);
    done_d   = (state_q == DONE);
    rd_vld_d = (state_q == IDLE) && i_rd_en;

    // Stage 2 forwards the previous write, which the RAM read raced against.
    rmw_base  = (wr_vld_q && (wr_code_q == s1_code_q)) ? wr_dat_q : ram_rdata;
    s1_vld_d  = hit_acc;
    s1_code_d = hit_acc ? i_hit_code : s1_code_q;
    wr_vld_d  = s1_vld_q;
    wr_code_d = s1_code_q;
    wr_dat_d  = CNT_W'(sat_inc(32'(rmw_base), 32'(CNT_MAX)));

    ram_we    = (state_q == CLEAR) || s1_vld_q;
    ram_waddr = (state_q == CLEAR) ? clr_addr_q : s1_code_q;
    ram_wdata = (state_q == CLEAR) ? '0 : wr_dat_d;
    ram_re    = hit_acc || rd_vld_d;
    ram_raddr = (state_q == IDLE) ? i_rd_addr : i_hit_code;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      clr_addr_q   <= '0;
      settle_cnt_q <= '0;
      hit_cnt_q    <= '0;
      s1_vld_q     <= 1'b0;
      s1_code_q    <= '0;
      wr_vld_q     <= 1'b0;
      wr_code_q    <= '0;
      wr_dat_q     <= '0;
      cali_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_vld_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      settle_cnt_q <= settle_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      s1_vld_q     <= s1_vld_d;
      s1_code_q    <= s1_code_d;
      wr_vld_q     <= wr_vld_d;
      wr_code_q    <= wr_code_d;
      wr_dat_q     <= wr_dat_d;
      cali_q       <= cali_d;
      done_q       <= done_d;
      rd_vld_q     <= rd_vld_d;
    end
  end

`ifdef TDC_CALI_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign o_timeout = tmo_q;
`else
  assign o_timeout = 1'b0;
`endif

  tdc_hist_ram #(
    .AW (CODE_W),
    .DW (CNT_W)
  ) u_ram (
    .clk   (i_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign o_cali_control = cali_q;
  assign o_busy         = (state_q == CLEAR) || (state_q == SETTLE) || (state_q == ACQUIRE);
  assign o_done         = done_q;
  assign o_rd_valid     = rd_vld_q;
  assign o_rd_data      = rd_vld_q ? ram_rdata : '0;

endmodule

// File: tb/tb_tdc_cali_ctrl.sv
// Directed bench: dut_a (N_HITS=8, full 4096-cycle settle) and dut_b (4-bit bins, N_HITS=20).
module tb_tdc_cali_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic       hit_vld;
  logic [6:0] hit_code;
  logic       rd_en;
  logic [6:0] rd_addr;

  logic        cali_a, busy_a, done_a, rd_vld_a, tmo_a;
  logic [15:0] rd_dat_a;
  logic        cali_b, busy_b, done_b, rd_vld_b, tmo_b;
  logic [3:0]  rd_dat_b;

  int checks = 0;
  int errors = 0;
  int n;
  int codes [8] = '{3, 3, 3, 5, 5, 7, 7, 7};

  always #5 clk = ~clk;

  tdc_cali_ctrl #(
    .CODE_W (7), .CNT_W (16), .N_HITS (8), .SETTLE_CYC (4096), .TIMEOUT_CYC (100)
  ) dut_a (
    .i_clk (clk), .i_reset (rst), .i_start (start_a),
    .i_hit_valid (hit_vld), .i_hit_code (hit_code),
    .i_rd_en (rd_en), .i_rd_addr (rd_addr),
    .o_cali_control (cali_a), .o_busy (busy_a), .o_done (done_a),
    .o_rd_valid (rd_vld_a), .o_rd_data (rd_dat_a), .o_timeout (tmo_a)
  );

  tdc_cali_ctrl #(
    .CODE_W (7), .CNT_W (4), .N_HITS (20), .SETTLE_CYC (8), .TIMEOUT_CYC (100)
  ) dut_b (
    .i_clk (clk), .i_reset (rst), .i_start (start_b),
    .i_hit_valid (hit_vld), .i_hit_code (hit_code),
    .i_rd_en (rd_en), .i_rd_addr (rd_addr),
    .o_cali_control (cali_b), .o_busy (busy_b), .o_done (done_b),
    .o_rd_valid (rd_vld_b), .o_rd_data (rd_dat_b), .o_timeout (tmo_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_bin(input int a);
    case (a)
      3:       return 3;
      5:       return 2;
      7:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic wait_cali_a();
    n = 0;
    while (!cali_a && n < 400) begin
      step();
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    hit_vld = 1'b0; hit_code = '0; rd_en = 1'b0; rd_addr = '0;
    #1;
    chk("rst_cali", 32'(cali_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_rd_vld", 32'(rd_vld_a), 0);
    chk("rst_rd_dat", 32'(rd_dat_a), 0);
    chk("rst_tmo", 32'(tmo_a), 0);
    repeat (2) step();
    rst = 1'b0;
    step();

    // Run 1: clear length, settle length, settle hits and start-while-busy ignored.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("clr_busy", 32'(busy_a), 1);
    chk("clr_cali", 32'(cali_a), 0);
    wait_cali_a();
    chk("clear_len", 32'(n), 128);
    chk("settle_busy", 32'(busy_a), 1);
    hit_vld = 1'b1; hit_code = 7'd0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("start_ignored_busy", 32'(busy_a), 1);
    n = 1;
    while (!done_a && n < 5000) begin
      step();
      n++;
    end
    chk("settle_to_done", 32'(n), 4096 + 9);
    hit_vld = 1'b0;
    chk("done_cali_off", 32'(cali_a), 0);
    chk("done_busy_off", 32'(busy_a), 0);
    step();
    chk("done_one_cycle", 32'(done_a), 0);
    rd_en = 1'b1; rd_addr = 7'd0;
    step();
    rd_en = 1'b0;
    chk("r1_rd_vld", 32'(rd_vld_a), 1);
    chk("r1_bin0", 32'(rd_dat_a), 8);
    step();
    chk("r1_rd_vld_low", 32'(rd_vld_a), 0);

    // Run 2: abort by reset in ACQUIRE, checked without a clock edge.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_cali_a();
    repeat (4096) step();
    hit_vld = 1'b1; hit_code = 7'd5;
    repeat (3) step();
    chk("acq_cali", 32'(cali_a), 1);
    chk("acq_busy", 32'(busy_a), 1);
    rst = 1'b1;
    #1;
    chk("rst_async_cali", 32'(cali_a), 0);
    chk("rst_async_busy", 32'(busy_a), 0);
    hit_vld = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Run 3: back-to-back hits with forwarding, then a full histogram read.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_cali_a();
    chk("r3_cali_rise", 32'(n), 128);
    rd_en = 1'b1; rd_addr = 7'd3;
    step();
    rd_en = 1'b0;
    chk("rd_drop_busy", 32'(rd_vld_a), 0);
    repeat (4095) step();
    for (int i = 0; i < 8; i++) begin
      hit_vld = 1'b1; hit_code = 7'(codes[i]);
      step();
    end
    hit_vld = 1'b0;
    chk("done_lat1", 32'(done_a), 0);
    chk("cali_off_done", 32'(cali_a), 0);
    step();
    chk("done_lat2", 32'(done_a), 1);
    step();
    chk("done_pulse_end", 32'(done_a), 0);
    for (int a = 0; a < 128; a++) begin
      rd_en = 1'b1; rd_addr = 7'(a);
      step();
      chk($sformatf("rd_vld%0d", a), 32'(rd_vld_a), 1);
      chk($sformatf("bin%0d", a), 32'(rd_dat_a), 32'(exp_bin(a)));
    end
    rd_en = 1'b0;
    step();

    // Run B: saturation at 15 and exact hit count with 4-bit bins.
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    n = 0;
    while (!cali_b && n < 400) begin
      step();
      n++;
    end
    chk("b_clear_len", 32'(n), 128);
    repeat (8) step();
    hit_vld = 1'b1; hit_code = 7'd9;
    n = 0;
    while (!done_b && n < 100) begin
      step();
      n++;
    end
    hit_vld = 1'b0;
    chk("b_hits_to_done", 32'(n), 21);
    chk("b_busy_off", 32'(busy_b), 0);
    rd_en = 1'b1; rd_addr = 7'd9;
    step();
    chk("b_bin9_sat", 32'(rd_dat_b), 15);
    rd_addr = 7'd8;
    step();
    chk("b_bin8", 32'(rd_dat_b), 0);
    rd_en = 1'b0;
    step();

`ifdef TDC_CALI_TIMEOUT_EN
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_cali_a();
    repeat (4096) step();
    hit_vld = 1'b1; hit_code = 7'd11;
    repeat (3) step();
    hit_vld = 1'b0;
    n = 3;
    while (!done_a && n < 300) begin
      step();
      n++;
    end
    chk("tmo_to_done", 32'(n), 101);
    chk("tmo_flag", 32'(tmo_a), 1);
    step();
    chk("tmo_done_once", 32'(done_a), 0);
    chk("tmo_sticky", 32'(tmo_a), 1);
    rd_en = 1'b1; rd_addr = 7'd11;
    step();
    rd_en = 1'b0;
    chk("tmo_bin11", 32'(rd_dat_a), 3);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("tmo_clr_on_start", 32'(tmo_a), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
`else
    chk("tmo_tied_a", 32'(tmo_a), 0);
    chk("tmo_tied_b", 32'(tmo_b), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
